// File: rtl/battle_turn_ctrl_pkg.sv
// battle_pkg: shared types and defaults for the battle turn controller.
package battle_pkg;

    localparam int HP_W = 8;
    localparam logic [HP_W-1:0] HP_INIT_DEF = 8'd30;
    localparam logic [3:0] LFSR_SEED_DEF = 4'b0001;

    typedef enum logic [2:0] {IDLE, SEL_A, HIT_A, SEL_B, HIT_B, END, OVER} state_e;

    typedef enum logic [1:0] {MV_JAB = 2'b00, MV_KICK = 2'b01, MV_SLAM = 2'b10, MV_NOVA = 2'b11} move_e;

    function automatic logic [HP_W-1:0] hp_sub(input logic [HP_W-1:0] hp, input logic [3:0] dmg);
        return (hp > HP_W'(dmg)) ? hp - HP_W'(dmg) : '0;
    endfunction

endpackage

// File: rtl/battle_turn_ctrl_if.sv
// battle_turn_ctrl_if: player, move_mux and status signals of one battle controller.
interface battle_turn_ctrl_if;
    import battle_pkg::*;

    logic [1:0]      p1_move, p2_move;
    logic            p1_valid, p2_valid;
    logic [1:0]      mux_move;
    logic [3:0]      mux_dmg, mux_accu;
    logic [HP_W-1:0] p1_hp, p2_hp;
    logic            busy, turn_done, hit_first, hit_second, first_p2, game_over, winner;

    modport master (
        output p1_move, p2_move, p1_valid, p2_valid, mux_dmg, mux_accu,
        input  mux_move, p1_hp, p2_hp, busy, turn_done, hit_first, hit_second, first_p2, game_over, winner
    );

    modport slave (
        input  p1_move, p2_move, p1_valid, p2_valid, mux_dmg, mux_accu,
        output mux_move, p1_hp, p2_hp, busy, turn_done, hit_first, hit_second, first_p2, game_over, winner
    );

endinterface

// File: rtl/battle_turn_ctrl_lfsr.sv
// battle_lfsr4: 4-bit maximal-length LFSR supplying hit rolls, stepping only on advance.
module battle_lfsr4
    import battle_pkg::*;
#(
    parameter logic [3:0] SEED = LFSR_SEED_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [3:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= SEED;
        else if (advance)
            q <= {q[2:0], q[3] ^ q[2]};
    end

endmodule

// File: rtl/battle_turn_ctrl.sv
// battle_turn_ctrl: collects both players' moves, resolves two attacks per turn against an
// external move_mux and tracks HP until one side is knocked out.
module battle_turn_ctrl
    import battle_pkg::*;
#(
    parameter logic [HP_W-1:0] HP_INIT   = HP_INIT_DEF,
    parameter logic [3:0]      LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      p1_move,
    input  logic [1:0]      p2_move,
    input  logic            p1_valid,
    input  logic            p2_valid,
    output logic [1:0]      mux_move,
    input  logic [3:0]      mux_dmg,
    input  logic [3:0]      mux_accu,
    output logic [HP_W-1:0] p1_hp,
    output logic [HP_W-1:0] p2_hp,
    output logic            busy,
    output logic            turn_done,
    output logic            hit_first,
    output logic            hit_second,
    output logic            first_p2,
    output logic            game_over,
    output logic            winner
);

    state_e          state_q, state_d;
    logic            p1_full_q, p1_full_d, p2_full_q, p2_full_d;
    logic [1:0]      p1_mv_q, p1_mv_d, p2_mv_q, p2_mv_d, mux_move_q, mux_move_d;
    logic [HP_W-1:0] p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
    logic            hit_first_q, hit_first_d, hit_second_q, hit_second_d;
    logic            first_p2_q, first_p2_d, game_over_q, game_over_d, winner_q, winner_d;
    logic [3:0]      roll;
    logic            advance, hit, atk_p2;
    logic [HP_W-1:0] def_hp, new_hp;

    battle_lfsr4 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .q       (roll)
    );

    // The first attacker swings in HIT_A, the other player in HIT_B.
    assign atk_p2 = (state_q == HIT_A) ? first_p2_q : ~first_p2_q;
    assign def_hp = atk_p2 ? p1_hp_q : p2_hp_q;
    assign hit    = roll <= mux_accu;
    assign new_hp = hit ? hp_sub(def_hp, mux_dmg) : def_hp;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_full_q    <= 1'b0;
            p2_full_q    <= 1'b0;
            p1_mv_q      <= '0;
            p2_mv_q      <= '0;
            mux_move_q   <= '0;
            p1_hp_q      <= HP_INIT;
            p2_hp_q      <= HP_INIT;
            hit_first_q  <= 1'b0;
            hit_second_q <= 1'b0;
            first_p2_q   <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            p1_full_q    <= p1_full_d;
            p2_full_q    <= p2_full_d;
            p1_mv_q      <= p1_mv_d;
            p2_mv_q      <= p2_mv_d;
            mux_move_q   <= mux_move_d;
            p1_hp_q      <= p1_hp_d;
            p2_hp_q      <= p2_hp_d;
            hit_first_q  <= hit_first_d;
            hit_second_q <= hit_second_d;
            first_p2_q   <= first_p2_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        p1_full_d    = p1_full_q;
        p2_full_d    = p2_full_q;
        p1_mv_d      = p1_mv_q;
        p2_mv_d      = p2_mv_q;
        mux_move_d   = mux_move_q;
        p1_hp_d      = p1_hp_q;
        p2_hp_d      = p2_hp_q;
        hit_first_d  = hit_first_q;
        hit_second_d = hit_second_q;
        first_p2_d   = first_p2_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        advance      = 1'b0;
        if (state_q != OVER && p1_valid && !p1_full_q) begin
            p1_full_d = 1'b1;
            p1_mv_d   = p1_move;
        end
        if (state_q != OVER && p2_valid && !p2_full_q) begin
            p2_full_d = 1'b1;
            p2_mv_d   = p2_move;
        end
        case (state_q)
            IDLE: begin
                if (p1_full_q && p2_full_q) begin
                    state_d    = SEL_A;
                    mux_move_d = first_p2_q ? p2_mv_q : p1_mv_q;
                end
            end
            SEL_A: state_d = HIT_A;
            SEL_B: state_d = HIT_B;
            HIT_A, HIT_B: begin
                advance = 1'b1;
                if (state_q == HIT_A)
                    hit_first_d = hit;
                else
                    hit_second_d = hit;
                if (atk_p2)
                    p1_hp_d = new_hp;
                else
                    p2_hp_d = new_hp;
                if (hit && new_hp == '0) begin
                    state_d     = OVER;
                    game_over_d = 1'b1;
                    winner_d    = atk_p2;
                end else if (state_q == HIT_A) begin
                    state_d    = SEL_B;
                    mux_move_d = first_p2_q ? p1_mv_q : p2_mv_q;
                end else begin
                    state_d = END;
                end
            end
            // Valids seen in END are dropped; the slots clear on this edge.
            END: begin
                state_d    = IDLE;
                p1_full_d  = 1'b0;
                p2_full_d  = 1'b0;
                first_p2_d = ~first_p2_q;
            end
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    assign mux_move   = mux_move_q;
    assign p1_hp      = p1_hp_q;
    assign p2_hp      = p2_hp_q;
    assign busy       = state_q inside {SEL_A, HIT_A, SEL_B, HIT_B, END};
    assign turn_done  = state_q == END;
    assign hit_first  = hit_first_q;
    assign hit_second = hit_second_q;
    assign first_p2   = first_p2_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// tb_battle_turn_ctrl: directed turns against two controllers (HP 30 and HP 8) with a move_mux model.
module tb_battle_turn_ctrl;
    import battle_pkg::*;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    battle_turn_ctrl_if ia ();
    battle_turn_ctrl_if ib ();

    // move_mux model: 00 -> 1/10, 01 -> 3/8, 10 -> 5/7, 11 -> 11/3 (dmg/accu)
    function automatic logic [3:0] mv_dmg(input logic [1:0] m);
        return (m == 2'd0) ? 4'd1 : (m == 2'd1) ? 4'd3 : (m == 2'd2) ? 4'd5 : 4'd11;
    endfunction

    function automatic logic [3:0] mv_accu(input logic [1:0] m);
        return (m == 2'd0) ? 4'd10 : (m == 2'd1) ? 4'd8 : (m == 2'd2) ? 4'd7 : 4'd3;
    endfunction

    assign ia.mux_dmg  = mv_dmg(ia.mux_move);
    assign ia.mux_accu = mv_accu(ia.mux_move);
    assign ib.mux_dmg  = mv_dmg(ib.mux_move);
    assign ib.mux_accu = mv_accu(ib.mux_move);

    battle_turn_ctrl u_a (
        .clk(clk), .reset(rst_a),
        .p1_move(ia.p1_move), .p2_move(ia.p2_move), .p1_valid(ia.p1_valid), .p2_valid(ia.p2_valid),
        .mux_move(ia.mux_move), .mux_dmg(ia.mux_dmg), .mux_accu(ia.mux_accu),
        .p1_hp(ia.p1_hp), .p2_hp(ia.p2_hp), .busy(ia.busy), .turn_done(ia.turn_done),
        .hit_first(ia.hit_first), .hit_second(ia.hit_second), .first_p2(ia.first_p2),
        .game_over(ia.game_over), .winner(ia.winner)
    );

    battle_turn_ctrl #(.HP_INIT(8'd8)) u_b (
        .clk(clk), .reset(rst_b),
        .p1_move(ib.p1_move), .p2_move(ib.p2_move), .p1_valid(ib.p1_valid), .p2_valid(ib.p2_valid),
        .mux_move(ib.mux_move), .mux_dmg(ib.mux_dmg), .mux_accu(ib.mux_accu),
        .p1_hp(ib.p1_hp), .p2_hp(ib.p2_hp), .busy(ib.busy), .turn_done(ib.turn_done),
        .hit_first(ib.hit_first), .hit_second(ib.hit_second), .first_p2(ib.first_p2),
        .game_over(ib.game_over), .winner(ib.winner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sub_a(input logic [1:0] m1, input logic [1:0] m2);
        ia.p1_move  = m1;
        ia.p2_move  = m2;
        ia.p1_valid = 1'b1;
        ia.p2_valid = 1'b1;
        tick();
        ia.p1_valid = 1'b0;
        ia.p2_valid = 1'b0;
    endtask

    initial begin
        ia.p1_move = '0; ia.p2_move = '0; ia.p1_valid = 1'b0; ia.p2_valid = 1'b0;
        ib.p1_move = '0; ib.p2_move = '0; ib.p1_valid = 1'b0; ib.p2_valid = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        chk("rst_p1_hp", ia.p1_hp, 30);
        chk("rst_p2_hp", ia.p2_hp, 30);
        chk("rst_busy", ia.busy, 0);
        chk("rst_turn_done", ia.turn_done, 0);
        chk("rst_mux_move", ia.mux_move, 0);
        chk("rst_first_p2", ia.first_p2, 0);
        chk("rst_game_over", ia.game_over, 0);
        chk("rst_hit_first", ia.hit_first, 0);

        // turn 1: P1 slam first (roll 1 hits), P2 jab (roll 2 hits)
        sub_a(2'd2, 2'd0);
        chk("t1_idle_busy", ia.busy, 0);
        tick();
        chk("t1_sela_busy", ia.busy, 1);
        chk("t1_sela_mux", ia.mux_move, 2);
        tick();
        chk("t1_hita_p2_hp", ia.p2_hp, 30);
        tick();
        chk("t1_selb_p2_hp", ia.p2_hp, 25);
        chk("t1_hit_first", ia.hit_first, 1);
        chk("t1_selb_mux", ia.mux_move, 0);
        chk("t1_selb_done", ia.turn_done, 0);
        tick();
        tick();
        chk("t1_end_p1_hp", ia.p1_hp, 29);
        chk("t1_hit_second", ia.hit_second, 1);
        chk("t1_end_done", ia.turn_done, 1);
        tick();
        chk("t1_idle_done", ia.turn_done, 0);
        chk("t1_idle_busy2", ia.busy, 0);
        chk("t1_first_p2", ia.first_p2, 1);

        // turn 2: P2 kick first (roll 4 hits), P1 nova (roll 9 misses)
        sub_a(2'd3, 2'd1);
        tick();
        chk("t2_sela_mux", ia.mux_move, 1);
        tick();
        tick();
        chk("t2_p1_hp", ia.p1_hp, 26);
        chk("t2_hit_first", ia.hit_first, 1);
        chk("t2_selb_mux", ia.mux_move, 3);
        tick();
        tick();
        chk("t2_p2_hp", ia.p2_hp, 25);
        chk("t2_hit_second", ia.hit_second, 0);
        chk("t2_end_done", ia.turn_done, 1);
        tick();
        chk("t2_first_p2", ia.first_p2, 0);

        // the first P1 submission is kept, the second dropped
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        ia.p1_move = 2'd1; ia.p1_valid = 1'b1;
        tick();
        ia.p1_move = 2'd3;
        tick();
        ia.p1_valid = 1'b0;
        ia.p2_move = 2'd0; ia.p2_valid = 1'b1;
        tick();
        ia.p2_valid = 1'b0;
        tick();
        chk("keep_mux", ia.mux_move, 1);
        tick();
        tick();
        chk("keep_p2_hp", ia.p2_hp, 27);
        tick();
        tick();
        chk("keep_p1_hp", ia.p1_hp, 29);
        tick();

        // reset during HIT_A aborts the turn and reseeds the LFSR
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        sub_a(2'd3, 2'd0);
        tick();
        tick();
        chk("abort_in_hita", ia.busy, 1);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("abort_p1_hp", ia.p1_hp, 30);
        chk("abort_p2_hp", ia.p2_hp, 30);
        chk("abort_busy", ia.busy, 0);
        chk("abort_mux", ia.mux_move, 0);
        tick();
        tick();
        chk("abort_slots_empty", ia.busy, 0);
        sub_a(2'd3, 2'd0);
        tick();
        tick();
        tick();
        chk("abort_roll1_p2_hp", ia.p2_hp, 19);
        chk("abort_roll1_hit", ia.hit_first, 1);
        tick();
        tick();
        chk("abort_roll2_p1_hp", ia.p1_hp, 29);
        tick();

        // HP 8: one nova knocks P2 out, second attack skipped
        rst_b = 1'b0;
        chk("b_rst_p1_hp", ib.p1_hp, 8);
        chk("b_rst_p2_hp", ib.p2_hp, 8);
        ib.p1_move = 2'd3; ib.p2_move = 2'd0; ib.p1_valid = 1'b1; ib.p2_valid = 1'b1;
        tick();
        ib.p1_valid = 1'b0; ib.p2_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("ko_p2_hp", ib.p2_hp, 0);
        chk("ko_p1_hp", ib.p1_hp, 8);
        chk("ko_game_over", ib.game_over, 1);
        chk("ko_winner", ib.winner, 0);
        chk("ko_busy", ib.busy, 0);
        chk("ko_hit_first", ib.hit_first, 1);

        // OVER ignores valids
        ib.p1_move = 2'd2; ib.p2_move = 2'd2; ib.p1_valid = 1'b1; ib.p2_valid = 1'b1;
        tick();
        ib.p1_valid = 1'b0; ib.p2_valid = 1'b0;
        tick();
        chk("over_busy", ib.busy, 0);
        tick();
        chk("over_busy2", ib.busy, 0);
        chk("over_done", ib.turn_done, 0);
        chk("over_game_over", ib.game_over, 1);
        chk("over_mux", ib.mux_move, 3);
        chk("over_p1_hp", ib.p1_hp, 8);
        chk("over_hit_second", ib.hit_second, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/battle_turn_ctrl.md
BATTLE_TURN_CTRL -- requirements
Module: battle_turn_ctrl

Interface
REQ-001 SHALL have parameter HP_INIT, default 8'd30: starting HP of both players.
REQ-002 SHALL have parameter LFSR_SEED, default 4'b0001: RNG value after reset; must be nonzero.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have ports p1_move and p2_move, input, 2 each: player move codes.
REQ-006 SHALL have ports p1_valid and p2_valid, input, 1 each: move-submit strobes.
REQ-007 SHALL have port mux_move, output, 2: drives the shared move_mux select.
REQ-008 SHALL have ports mux_dmg and mux_accu, input, 4 each: move_mux results for mux_move.
REQ-009 SHALL have ports p1_hp and p2_hp, output, 8 each: current HP.
REQ-010 SHALL have port busy, output, 1: turn in progress.
REQ-011 SHALL have port turn_done, output, 1: one-cycle end-of-turn pulse.
REQ-012 SHALL have ports hit_first and hit_second, output, 1 each: result of the last first and second attack.
REQ-013 SHALL have port first_p2, output, 1: P2 attacks first this turn.
REQ-014 SHALL have ports game_over and winner, output, 1 each: winner is 0 for P1, 1 for P2.

Function
REQ-015 SHALL latch a player's move into an empty slot when that player's valid is high and state is not OVER; a valid into a full slot SHALL be ignored, so the first move is kept.
REQ-016 SHALL have FSM states IDLE, SEL_A, HIT_A, SEL_B, HIT_B, END and OVER.
REQ-017 SHALL go IDLE->SEL_A in the cycle T after both slots are full.
REQ-018 SHALL then step one state per cycle: T+1 SEL_A, T+2 HIT_A, T+3 SEL_B, T+4 HIT_B, T+5 END, T+6 IDLE.
REQ-019 SHALL assert busy in states SEL_A through END, and in no other state.
REQ-020 SHALL register mux_move on entry to SEL_A (first attacker's move) and on entry to SEL_B (second attacker's move), and SHALL sample mux_dmg and mux_accu only in the HIT states.
REQ-021 In each HIT state, roll SHALL equal the current LFSR value, and the LFSR SHALL advance exactly once.
REQ-022 An attack SHALL hit when roll <= mux_accu.
REQ-023 SHALL make the LFSR 4-bit, shift left, feedback bit q[3]^q[2], period 15. From seed 0001 the rolls are 1, 2, 4, 9, 3, 6, ...
REQ-024 On a hit, defender HP SHALL become max(hp - dmg, 0) (saturating); on a miss, HP SHALL be unchanged.
REQ-025 SHALL update the matching hit_* flag in the same edge as the HP update.
REQ-026 If a hit leaves defender HP at 0 in HIT_A or HIT_B, next state SHALL be OVER: game_over=1, winner=attacker; the remaining attack SHALL be skipped with no further LFSR advance.
REQ-027 OVER SHALL be sticky until reset, with all valids ignored and busy=0.
REQ-028 In END, SHALL assert turn_done, clear both slots and toggle first_p2.
REQ-029 SHALL process valids arriving in END only after the slots clear, i.e. from the next cycle.
REQ-030 When both valids arrive in the same cycle, both SHALL latch.
REQ-031 A valid during busy for an empty slot SHALL be impossible, since both slots are full while busy.

Reset
REQ-032 On reset: state IDLE, slots empty, p1_hp=p2_hp=HP_INIT, LFSR=LFSR_SEED, mux_move=00, first_p2=0, and busy, turn_done, hit_first, hit_second, game_over and winner all 0.
REQ-033 Reset asserted in any state, including mid-turn, SHALL abort the turn and apply REQ-032 at the next edge, with no partial HP update retained.

Structure
REQ-034 Package battle_pkg SHALL hold the FSM state enum, move codes, HP width (8), default HP_INIT and default LFSR seed.
REQ-035 The LFSR SHALL be the single sub-module battle_lfsr4, with ports clk, reset, advance, q[3:0] and a seed parameter.
REQ-036 move_mux SHALL stay external, connected through mux_move, mux_dmg and mux_accu, so it can be shared with the display path.

Verification
REQ-037 Reset; p1=10 and p2=00 valid in the same cycle -> P1 first, roll 1 <= 7 hits, p2_hp=25; P2 roll 2 <= 10 hits, p1_hp=29; turn_done is a single pulse at T+5; first_p2=1 afterwards.
REQ-038 Continue; p1=11 and p2=01 -> P2 first, roll 4 <= 8 hits, p1_hp=26; P1 roll 9 > 3 misses, p2_hp=25, hit_second=0.
REQ-039 With HP_INIT=8, after reset p1=11 and p2=00 -> roll 1 <= 3, dmg 11 saturates p2_hp to 0, game_over=1, winner=0, p1_hp=8; the next turn's first roll would be 2, because only one LFSR advance occurred.
REQ-040 p1_valid with 01, then p1_valid with 11, then p2_valid with 00 -> the first attack uses mux_move=01; the later P1 submission is dropped.
REQ-041 Reset pulsed during HIT_A -> next cycle HP=30/30, busy=0, slots empty; the next turn's first roll is 1.
REQ-042 In OVER, pulse both valids -> no state change, busy=0, turn_done=0.
